uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter.
REQ-002 Parameter DATA_W, default 8, character width.
REQ-003 Parameter TIMEOUT_CYC, default 1024, max clk cycles from tx_start to tx_done.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester transmit request, level, held until granted.
REQ-007 req_data  input  NUM_REQ*DATA_W  flat data bus; requester i owns bits [i*DATA_W +: DATA_W].
REQ-008 grant  output  NUM_REQ  one-hot, one-cycle pulse; requester i's character accepted.
REQ-009 tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-010 tx_data  output  DATA_W  character to UART, stable from tx_start until tx_done or timeout.
REQ-011 tx_done  input  1  one-cycle frame-complete pulse from UART transmitter.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 owner  output  clog2(NUM_REQ)  index of last granted requester.
REQ-014 timeout  output  1  one-cycle pulse when TIMEOUT_CYC expires without tx_done.

Function
REQ-015 FSM states IDLE, ISSUE, WAIT; registered, one state per cycle minimum.
REQ-016 IDLE: if any req bit high at edge n, state ISSUE at n+1; else stay IDLE.
REQ-017 Winner: round-robin, first set req bit searching upward from ptr, wrapping NUM_REQ-1 -> 0.
REQ-018 ISSUE: grant[winner]=1, tx_start=1, tx_data=req_data slice of winner captured at edge n; owner=winner; ptr=(winner+1) mod NUM_REQ; next state WAIT.
REQ-019 Latency req->grant/tx_start: exactly one cycle from the IDLE sampling edge.
REQ-020 Request deasserted before sampling edge is not granted (withdrawal allowed); req_data is don't-care after grant.
REQ-021 WAIT: watchdog counter starts at 0 on entry, increments each cycle.
REQ-022 WAIT and tx_done=1: next state IDLE, counter cleared; no timeout pulse.
REQ-023 WAIT and counter==TIMEOUT_CYC-1 without tx_done: timeout=1 that cycle, next state IDLE.
REQ-024 tx_done and terminal count same cycle: tx_done wins, no timeout.
REQ-025 tx_done in IDLE or ISSUE ignored.
REQ-026 Back-to-back: IDLE entered after tx_done re-arbitrates next edge; min spacing between tx_start pulses = 3 cycles.
REQ-027 grant, tx_start, timeout never high outside ISSUE/WAIT as specified; grant at most one bit set.

Reset
REQ-028 rst high at edge: state IDLE, ptr=0, counter=0, owner=0, tx_data=0, grant=0, tx_start=0, timeout=0, busy=0.
REQ-029 rst mid-ISSUE/WAIT: abort immediately, no grant/timeout pulse, in-flight character dropped; next arbitration starts from ptr=0.

Structure
REQ-030 Shared package uart_pkg holds state enum (IDLE, ISSUE, WAIT) and default TIMEOUT_CYC constant.
REQ-031 One sub-module rr_arbiter: combinational round-robin pick from req and ptr, outputs one-hot and index.

Verification
REQ-032 Single: req=4'b0100, slice2=8'hA5 -> next cycle grant=4'b0100, tx_start=1, tx_data=8'hA5, owner=2; tx_done after 10 cycles -> busy low next cycle.
REQ-033 Fairness: req=4'b1111 held, data 8'h10..8'h13, ptr=0 -> grants in order 0,1,2,3,0 with tx_data 8'h10,8'h11,8'h12,8'h13,8'h10.
REQ-034 Wrap: ptr=3, req=4'b0011 -> grant 4'b0001, then 4'b0010.
REQ-035 Timeout: TIMEOUT_CYC=16, no tx_done -> timeout pulse 16 cycles after WAIT entry, IDLE next; tx_done on that terminal cycle -> no timeout.
REQ-036 Reset mid-WAIT: rst one cycle -> all outputs zero next cycle; late tx_done ignored; req=4'b1000 then grants requester 3 normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int TIMEOUT_CYC_DEFAULT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      cand = IDX_W'((int'(ptr) + off) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters with round-robin
// arbitration and a per-frame watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner,
  output logic                      timeout
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               tx_start_q;
  logic [DATA_W-1:0]  tx_data_q;

  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic [IDX_W-1:0]   ptr_d;

  logic [DATA_W-1:0] slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign slice[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N    (NUM_REQ),
    .IDX_W(IDX_W)
  ) u_rr (
    .req  (req),
    .ptr  (ptr_q),
    .gnt  (win_gnt),
    .idx  (win_idx),
    .valid(win_valid)
  );

  assign ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      grant_q    <= '0;
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q    <= ISSUE;
            grant_q    <= win_gnt;
            tx_start_q <= 1'b1;
            tx_data_q  <= slice[win_idx];
            owner_q    <= win_idx;
            ptr_q      <= ptr_d;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: begin
          // tx_done takes priority over an expiring watchdog
          if (tx_done || cnt_q == CNT_TERM) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign owner    = owner_q;
  assign busy     = (state_q != IDLE);
  // Suppressed in the same cycle by a late tx_done.
  assign timeout  = (state_q == WAIT) && (cnt_q == CNT_TERM) && !tx_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed checks of arbitration order, latency, watchdog and reset abort.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_W     (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_data(req_data),
    .grant   (grant),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tx_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    $display("reset: grant=%b busy=%b owner=%0d", grant, busy, owner);
  endtask

  task automatic test_single();
    do_reset();
    req_data = 32'h77A5_3322;
    req = 4'b0100;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_pre_grant: got %b expected 0000", grant); end
    step();
    req = 4'b0000;
    $display("single: grant=%b tx_start=%b tx_data=%h owner=%0d", grant, tx_start, tx_data, owner);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected 0100", grant); end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_tx_start: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data: got %h expected a5", tx_data); end
    checks++; if (owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected 2", owner); end
    step();
    checks++; if (grant !== 4'b0000 || tx_start !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got grant=%b tx_start=%b expected 0000/0", grant, tx_start); end
    for (int i = 0; i < 9; i++) step();
    checks++; if (busy !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL single_hold: got busy=%b tx_data=%h expected 1/a5", busy, tx_data); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    step();
    checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_stay_idle: got busy=%b grant=%b expected 0/0000", busy, grant); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    logic [7:0] exp_d [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    req_data = 32'h1312_1110;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      $display("fair[%0d]: grant=%b tx_start=%b tx_data=%h owner=%0d", k, grant, tx_start, tx_data, owner);
      checks++; if (grant !== exp_g[k] || tx_start !== 1'b1) begin errors++; $display("FAIL fair_grant[%0d]: got %b/%b expected %b/1", k, grant, tx_start, exp_g[k]); end
      checks++; if (tx_data !== exp_d[k]) begin errors++; $display("FAIL fair_data[%0d]: got %h expected %h", k, tx_data, exp_d[k]); end
      step();
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL fair_idle[%0d]: got busy=%b tx_start=%b expected 0/0", k, busy, tx_start); end
    end
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    do_reset();
    req_data = 32'hD3C2_B1A0;
    req = 4'b1000;
    step();
    req = 4'b0000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    req = 4'b0011;
    step();
    $display("wrap[0]: grant=%b tx_data=%h owner=%0d", grant, tx_data, owner);
    checks++; if (grant !== 4'b0001 || tx_data !== 8'hA0) begin errors++; $display("FAIL wrap_first: got %b/%h expected 0001/a0", grant, tx_data); end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    $display("wrap[1]: grant=%b tx_data=%h owner=%0d", grant, tx_data, owner);
    checks++; if (grant !== 4'b0010 || tx_data !== 8'hB1 || owner !== 2'd1) begin errors++; $display("FAIL wrap_second: got %b/%h/%0d expected 0010/b1/1", grant, tx_data, owner); end
    req = 4'b0000;
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_done_ignored: got busy=%b expected 0", busy); end
    req_data = 32'h0000_0055;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) begin
      if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early[%0d]: got timeout=%b busy=%b expected 0/1", i, timeout, busy); end
      checks++;
      step();
    end
    $display("timeout: timeout=%b busy=%b", timeout, busy);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", timeout); end
    step();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_after: got timeout=%b busy=%b expected 0/0", timeout, busy); end
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) step();
    tx_done = 1'b1;
    #1;
    $display("timeout_race: timeout=%b busy=%b", timeout, busy);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_race: got %b expected 0", timeout); end
    step();
    tx_done = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL to_race_idle: got busy=%b timeout=%b expected 0/0", busy, timeout); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_data = 32'h8800_7700;
    req = 4'b0100;
    step();
    req = 4'b0000;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset_mid_wait: grant=%b busy=%b owner=%0d tx_data=%h", grant, busy, owner, tx_data);
    checks++; if (grant !== 4'b0000 || tx_start !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL rmw_pulses: got %b/%b/%b expected 0000/0/0", grant, tx_start, timeout); end
    checks++; if (busy !== 1'b0 || owner !== 2'd0 || tx_data !== 8'h00) begin errors++; $display("FAIL rmw_state: got busy=%b owner=%0d tx_data=%h expected 0/0/00", busy, owner, tx_data); end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmw_late_done: got busy=%b expected 0", busy); end
    req_data = 32'h4400_0011;
    req = 4'b1001;
    step();
    req = 4'b0000;
    $display("reset_ptr: grant=%b owner=%0d tx_data=%h", grant, owner, tx_data);
    checks++; if (grant !== 4'b0001 || tx_data !== 8'h11) begin errors++; $display("FAIL rmw_ptr0: got %b/%h expected 0001/11", grant, tx_data); end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    req = 4'b1000;
    step();
    req = 4'b0000;
    $display("post_reset: grant=%b owner=%0d tx_data=%h", grant, owner, tx_data);
    checks++; if (grant !== 4'b1000 || owner !== 2'd3 || tx_data !== 8'h44) begin errors++; $display("FAIL rmw_req3: got %b/%0d/%h expected 1000/3/44", grant, owner, tx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
